rectangle_sbox_layer_ctrl: RTL and testbench

RECTANGLE_SBOX_LAYER_CTRL -- requirements
Module: rectangle_sbox_layer_ctrl

---
 rtl/rectangle_sbox_layer_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rectangle_sbox_layer_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rectangle_sbox_layer_ctrl.sv
// rectangle_sbox_layer_ctrl
//
// Sequences one RECTANGLE S-box layer over a 3-share masked 64-bit state.
// The layer is processed one 4-bit column at a time through an external
// pipelined masked S-box. The three input shares are never recombined here.
// Each share is handled separately end to end.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, accepted only in IDLE
//   st1, st2, st3       input shares; row k sits in bits [NCOL*k +: NCOL]
//   rnd_in, rnd_valid   fresh randomness (one byte per column) and its valid
//   rnd_ack             rnd_in consumed this cycle (column issued)
//   sb_in1..3, sb_r     column shares and randomness to the masked S-box
//   sb_out1..3          masked S-box output shares, valid LAT cycles after issue
//   res1, res2, res3    substituted output shares, same row layout as st*
//   busy                high from the start-accept edge until done
//   done                one-cycle pulse once all columns are captured
module rectangle_sbox_layer_ctrl #(
  parameter int unsigned LAT  = 3,
  parameter int unsigned NCOL = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NCOL-1:0] st1,
  input  logic [4*NCOL-1:0] st2,
  input  logic [4*NCOL-1:0] st3,
  input  logic [7:0]        rnd_in,
  input  logic              rnd_valid,
  output logic              rnd_ack,
  output logic [3:0]        sb_in1,
  output logic [3:0]        sb_in2,
  output logic [3:0]        sb_in3,
  output logic [7:0]        sb_r,
  input  logic [3:0]        sb_out1,
  input  logic [3:0]        sb_out2,
  input  logic [3:0]        sb_out3,
  output logic [4*NCOL-1:0] res1,
  output logic [4*NCOL-1:0] res2,
  output logic [4*NCOL-1:0] res3,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ColW = (NCOL > 1) ? $clog2(NCOL) : 1;
  typedef logic [ColW-1:0] col_t;
  localparam col_t LastCol = col_t'(NCOL - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q;
  col_t              col_q;
  logic [4*NCOL-1:0] st1_q, st2_q, st3_q;
  logic [4*NCOL-1:0] res1_q, res2_q, res3_q;
  logic              busy_q, done_q;

  // Tracker: stage LAT-1 holds the column whose S-box output is valid this cycle.
  logic [LAT-1:0]    vld_q;
  col_t              idx_q [LAT];

  logic              issue;
  logic              cap;
  col_t              cap_idx;

  assign issue   = (state_q == StIssue) && rnd_valid;
  assign cap     = vld_q[LAT-1];
  assign cap_idx = idx_q[LAT-1];

  // S-box drive is zero on every non-issue cycle so no stale share leaks out.
  always_comb begin
    sb_in1  = '0;
    sb_in2  = '0;
    sb_in3  = '0;
    sb_r    = '0;
    rnd_ack = 1'b0;
    if (issue) begin
      for (int k = 0; k < 4; k++) begin
        sb_in1[k] = st1_q[k*NCOL + int'(col_q)];
        sb_in2[k] = st2_q[k*NCOL + int'(col_q)];
        sb_in3[k] = st3_q[k*NCOL + int'(col_q)];
      end
      sb_r    = rnd_in;
      rnd_ack = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      st1_q   <= '0;
      st2_q   <= '0;
      st3_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      res3_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      // Bubbles enter the tracker as invalid slots, so they never capture.
      vld_q[0] <= issue;
      idx_q[0] <= col_q;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end

      if (cap) begin
        for (int k = 0; k < 4; k++) begin
          res1_q[k*NCOL + int'(cap_idx)] <= sb_out1[k];
          res2_q[k*NCOL + int'(cap_idx)] <= sb_out2[k];
          res3_q[k*NCOL + int'(cap_idx)] <= sb_out3[k];
        end
      end

      unique case (state_q)
        StIdle: begin
          // A start coinciding with done belongs to the run just finishing.
          if (start && !done_q) begin
            st1_q   <= st1;
            st2_q   <= st2;
            st3_q   <= st3;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (rnd_valid) begin
            if (col_q == LastCol) begin
              state_q <= StDrain;
            end else begin
              col_q <= col_q + col_t'(1);
            end
          end
        end
        StDrain: begin
          if (cap && (cap_idx == LastCol)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign res1 = res1_q;
  assign res2 = res2_q;
  assign res3 = res3_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_rectangle_sbox_layer_ctrl.sv
module tb_rectangle_sbox_layer_ctrl;

  localparam int unsigned LAT  = 3;
  localparam int unsigned NCOL = 16;

  logic        clk, rst_n, start;
  logic [63:0] st1, st2, st3;
  logic [7:0]  rnd_in;
  logic        rnd_valid, rnd_ack;
  logic [3:0]  sb_in1, sb_in2, sb_in3;
  logic [7:0]  sb_r;
  logic [3:0]  sb_out1, sb_out2, sb_out3;
  logic [63:0] res1, res2, res3;
  logic        busy, done;

  rectangle_sbox_layer_ctrl #(.LAT(LAT), .NCOL(NCOL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .st1      (st1),
    .st2      (st2),
    .st3      (st3),
    .rnd_in   (rnd_in),
    .rnd_valid(rnd_valid),
    .rnd_ack  (rnd_ack),
    .sb_in1   (sb_in1),
    .sb_in2   (sb_in2),
    .sb_in3   (sb_in3),
    .sb_r     (sb_r),
    .sb_out1  (sb_out1),
    .sb_out2  (sb_out2),
    .sb_out3  (sb_out3),
    .res1     (res1),
    .res2     (res2),
    .res3     (res3),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h6; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'hC; 4'h3: sbox = 4'hA;
      4'h4: sbox = 4'h1; 4'h5: sbox = 4'hE; 4'h6: sbox = 4'h7; 4'h7: sbox = 4'h9;
      4'h8: sbox = 4'hB; 4'h9: sbox = 4'h0; 4'hA: sbox = 4'h3; 4'hB: sbox = 4'hD;
      4'hC: sbox = 4'h8; 4'hD: sbox = 4'hF; 4'hE: sbox = 4'h4; default: sbox = 4'h2;
    endcase
  endfunction

  // Bitsliced reference S-layer on the unmasked state.
  function automatic logic [63:0] slayer(input logic [63:0] s);
    logic [63:0] r;
    logic [3:0]  x, y;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      x = {s[48+j], s[32+j], s[16+j], s[j]};
      y = sbox(x);
      r[j] = y[0]; r[16+j] = y[1]; r[32+j] = y[2]; r[48+j] = y[3];
    end
    return r;
  endfunction

  // Ideal masked S-box, LAT-cycle pipeline, output shares re-masked from sb_r.
  logic [3:0] p1 [LAT] = '{default: 4'h0};
  logic [3:0] p2 [LAT] = '{default: 4'h0};
  logic [3:0] p3 [LAT] = '{default: 4'h0};
  logic [7:0] pr [LAT] = '{default: 8'h0};
  logic [3:0] sb_x;

  always @(posedge clk) begin
    p1[0] <= sb_in1; p2[0] <= sb_in2; p3[0] <= sb_in3; pr[0] <= sb_r;
    for (int i = 1; i < LAT; i++) begin
      p1[i] <= p1[i-1]; p2[i] <= p2[i-1]; p3[i] <= p3[i-1]; pr[i] <= pr[i-1];
    end
  end

  assign sb_x    = p1[LAT-1] ^ p2[LAT-1] ^ p3[LAT-1];
  assign sb_out1 = sbox(sb_x) ^ pr[LAT-1][3:0] ^ pr[LAT-1][7:4];
  assign sb_out2 = pr[LAT-1][3:0];
  assign sb_out3 = pr[LAT-1][7:4];

  int checks = 0;
  int failures = 0;

  // Per-run observations collected by step(); compared by the test tasks.
  int   cyc, n_ack, n_done, done_cyc, sbr_bad, dup, idle_bad, busy_bad, b3, b10;
  bit   used [256];
  bit   bub_mode, pulse_mode, sd_mode;
  bit   last_busy;
  logic [7:0]  rnd_base;
  logic [63:0] exp_q [$];
  logic [63:0] e;

  task automatic step();
    bit bub;
    @(negedge clk);
    bub = 1'b0;
    if (bub_mode && n_ack == 3 && b3 < 2) begin bub = 1'b1; b3++; end
    if (bub_mode && n_ack == 10 && b10 < 2) begin bub = 1'b1; b10++; end
    rnd_valid = !bub;
    rnd_in    = rnd_base + 8'(cyc);
    start     = 1'b0;
    if (pulse_mode) begin
      start = (cyc == 5 || cyc == 12);
      if (cyc == 1) begin
        st1 = {$urandom, $urandom}; st2 = {$urandom, $urandom}; st3 = {$urandom, $urandom};
      end
    end
    if (sd_mode) start = (cyc == 19);
    #1;
    if (rnd_ack) begin
      n_ack++;
      if (sb_r !== rnd_in) sbr_bad++;
      if (used[sb_r]) dup++;
      used[sb_r] = 1'b1;
    end else if ((sb_in1 | sb_in2 | sb_in3) !== 4'h0 || sb_r !== 8'h0) begin
      idle_bad++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (busy) busy_bad++;
    end
    last_busy = busy;
    @(posedge clk);
    cyc++;
  endtask

  task automatic start_run(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] expv);
    @(negedge clk);
    st1 = a; st2 = b; st3 = c;
    start = 1'b1;
    rnd_valid = 1'b0;
    exp_q.push_back(expv);
    n_ack = 0; n_done = 0; done_cyc = -1; sbr_bad = 0; dup = 0; idle_bad = 0;
    busy_bad = 0; b3 = 0; b10 = 0;
    for (int i = 0; i < 256; i++) used[i] = 1'b0;
    rnd_base = 8'($urandom);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
  endtask

  task automatic drive_run(input logic [63:0] x);
    logic [63:0] m1, m2;
    m1 = {$urandom, $urandom};
    m2 = {$urandom, $urandom};
    start_run(x ^ m1 ^ m2, m1, m2, slayer(x));
    while (n_done == 0 && cyc < 80) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b1; rnd_in = 8'hA5;
    st1 = '1; st2 = '1; st3 = '0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if ((res1 | res2 | res3) !== 64'h0) begin
      failures++; $display("FAIL reset_res got %h %h %h required 0", res1, res2, res3);
    end
    checks++;
    if (rnd_ack !== 1'b0 || sb_r !== 8'h0 || (sb_in1 | sb_in2 | sb_in3) !== 4'h0) begin
      failures++; $display("FAIL reset_sbox ack=%b sb_r=%h required 0 0", rnd_ack, sb_r);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_zero();
    drive_run(64'h0);
    checks++;
    if (n_done == 0) begin
      failures++; $display("FAIL zero_timeout no done within 80 cycles");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ((res1 ^ res2 ^ res3) !== 64'h0000FFFFFFFF0000 || e !== 64'h0000FFFFFFFF0000) begin
        failures++;
        $display("FAIL zero_result got %h required %h", res1 ^ res2 ^ res3, 64'h0000FFFFFFFF0000);
      end
    end
    checks++;
    if (done_cyc !== 19) begin
      failures++; $display("FAIL zero_done_cycle got %0d required 19", done_cyc);
    end
    checks++;
    if (n_ack !== 16 || sbr_bad !== 0 || dup !== 0) begin
      failures++;
      $display("FAIL sbr_usage acks=%0d bad=%0d dup=%0d required 16 0 0", n_ack, sbr_bad, dup);
    end
    checks++;
    if (idle_bad !== 0 || busy_bad !== 0) begin
      failures++;
      $display("FAIL zero_idle_drive idle_bad=%0d busy_bad=%0d required 0 0", idle_bad, busy_bad);
    end
    // Results must hold while idle.
    repeat (5) step();
    checks++;
    if ((res1 ^ res2 ^ res3) !== 64'h0000FFFFFFFF0000 || n_done !== 1) begin
      failures++; $display("FAIL zero_hold got %h dones=%0d required %h 1",
                           res1 ^ res2 ^ res3, n_done, 64'h0000FFFFFFFF0000);
    end
  endtask

  task automatic test_random();
    int bad_res = 0, bad_share = 0, bad_cyc = 0, bad_use = 0;
    logic [63:0] x;
    for (int r = 0; r < 200; r++) begin
      x = {$urandom, $urandom};
      drive_run(x);
      checks++;
      if (n_done == 0) begin
        failures++; $display("FAIL random_timeout run=%0d no done", r);
        return;
      end
      e = exp_q.pop_front();
      checks++;
      if ((res1 ^ res2 ^ res3) !== e) begin
        failures++; bad_res++;
        if (bad_res < 4) $display("FAIL random_result run=%0d got %h required %h",
                                  r, res1 ^ res2 ^ res3, e);
      end
      checks++;
      if (res1 === e || res2 === e || res3 === e) begin
        failures++; bad_share++;
        if (bad_share < 4) $display("FAIL random_share_unmasked run=%0d value %h", r, e);
      end
      checks++;
      if (done_cyc !== 19 || busy_bad !== 0) begin
        failures++; bad_cyc++;
        if (bad_cyc < 4) $display("FAIL random_done run=%0d cycle=%0d busy_bad=%0d required 19 0",
                                  r, done_cyc, busy_bad);
      end
      checks++;
      if (n_ack !== 16 || sbr_bad !== 0 || dup !== 0 || idle_bad !== 0) begin
        failures++; bad_use++;
        if (bad_use < 4) $display("FAIL random_issue run=%0d acks=%0d sbr_bad=%0d idle_bad=%0d",
                                  r, n_ack, sbr_bad, idle_bad);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [63:0] x;
    x = {$urandom, $urandom};
    bub_mode = 1'b1;
    drive_run(x);
    bub_mode = 1'b0;
    checks++;
    if (n_done == 0) begin
      failures++; $display("FAIL bubble_timeout no done");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ((res1 ^ res2 ^ res3) !== e) begin
        failures++; $display("FAIL bubble_result got %h required %h", res1 ^ res2 ^ res3, e);
      end
    end
    checks++;
    if (done_cyc !== 23) begin
      failures++; $display("FAIL bubble_done_cycle got %0d required 23", done_cyc);
    end
    checks++;
    if (b3 !== 2 || b10 !== 2 || n_ack !== 16 || idle_bad !== 0 || sbr_bad !== 0) begin
      failures++; $display("FAIL bubble_issue b3=%0d b10=%0d acks=%0d idle_bad=%0d required 2 2 16 0",
                           b3, b10, n_ack, idle_bad);
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] x;
    x = {$urandom, $urandom};
    pulse_mode = 1'b1;
    drive_run(x);
    repeat (6) step();
    pulse_mode = 1'b0;
    checks++;
    if (n_done !== 1 || last_busy !== 1'b0) begin
      failures++; $display("FAIL start_ignored dones=%0d busy=%b required 1 0", n_done, last_busy);
    end
    if (n_done != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ((res1 ^ res2 ^ res3) !== e) begin
        failures++; $display("FAIL start_ignored_result got %h required %h", res1 ^ res2 ^ res3, e);
      end
    end
  endtask

  task automatic test_start_at_done();
    logic [63:0] x;
    x = {$urandom, $urandom};
    sd_mode = 1'b1;
    drive_run(x);
    sd_mode = 1'b0;
    if (n_done != 0) e = exp_q.pop_front();
    step();
    checks++;
    if (last_busy !== 1'b0 || done_cyc !== 19) begin
      failures++; $display("FAIL start_at_done busy=%b done_cycle=%0d required 0 19",
                           last_busy, done_cyc);
    end
    repeat (3) step();
    checks++;
    if (last_busy !== 1'b0 || n_ack !== 16) begin
      failures++; $display("FAIL start_at_done_later busy=%b acks=%0d required 0 16",
                           last_busy, n_ack);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] x;
    x = {$urandom, $urandom};
    start_run(x, 64'h0, 64'h0, slayer(x));
    while (cyc < 9) step();
    @(negedge clk);
    rnd_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rnd_ack !== 1'b0 || sb_r !== 8'h0) begin
      failures++; $display("FAIL midreset_ctrl busy=%b done=%b ack=%b sb_r=%h required 0 0 0 0",
                           busy, done, rnd_ack, sb_r);
    end
    checks++;
    if ((res1 | res2 | res3) !== 64'h0) begin
      failures++; $display("FAIL midreset_res got %h %h %h required 0", res1, res2, res3);
    end
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n_done = 0; n_ack = 0;
    repeat (10) step();
    checks++;
    if (n_done !== 0 || n_ack !== 0 || (res1 | res2 | res3) !== 64'h0) begin
      failures++; $display("FAIL midreset_after dones=%0d acks=%0d res=%h required 0 0 0",
                           n_done, n_ack, res1 | res2 | res3);
    end
    x = {$urandom, $urandom};
    drive_run(x);
    checks++;
    if (n_done == 0) begin
      failures++; $display("FAIL midreset_rerun_timeout no done");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ((res1 ^ res2 ^ res3) !== e || done_cyc !== 19) begin
        failures++; $display("FAIL midreset_rerun got %h cycle=%0d required %h 19",
                             res1 ^ res2 ^ res3, done_cyc, e);
      end
    end
  endtask

  initial begin
    bub_mode = 1'b0; pulse_mode = 1'b0; sd_mode = 1'b0;
    cyc = 0; n_ack = 0; n_done = 0; rnd_base = 8'h0;
    test_reset();
    test_zero();
    test_random();
    test_bubbles();
    test_start_ignored();
    test_start_at_done();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++; $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
